// File: rtl/seq_mult4_if.sv
// seq_mult4 handshake bundle: start/operands in, busy/done/product out.
// Master drives a request, slave (the multiplier) answers.
interface seq_mult4_if #(
  parameter int WIDTH = 4
);
  logic               start;
  logic [WIDTH-1:0]   m;
  logic [WIDTH-1:0]   n;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] z;

  modport master (
    output start, m, n,
    input  busy, done, z
  );

  modport slave (
    input  start, m, n,
    output busy, done, z
  );
endinterface

// File: rtl/seq_mult4.sv
// seq_mult4: shift-and-add multiplier, one conditional add per cycle.
// Define SEQ_MULT_SIGNED_EN for two's complement operands.
module seq_mult4 #(
  parameter int WIDTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  seq_mult4_if.slave  bus
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   acc_q;
  logic [WIDTH-1:0]   q_q;
  logic [CW-1:0]      cnt_q;
  logic [2*WIDTH-1:0] z_q;

  logic [WIDTH-1:0]   addend;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] prod_nx;
  logic [2*WIDTH-1:0] z_nx;
  logic [WIDTH-1:0]   mag_m;
  logic [WIDTH-1:0]   mag_n;
  logic               last;

  // The carry out of the add lands directly in acc msb after the
  // shift, so it needs no separate storage between iterations.
  assign addend  = q_q[0] ? a_q : '0;
  assign sum     = {1'b0, acc_q} + {1'b0, addend};
  assign prod_nx = {sum, q_q[WIDTH-1:1]};
  assign last    = (cnt_q == CW'(WIDTH - 1));

`ifdef SEQ_MULT_SIGNED_EN
  logic sign_q;

  assign mag_m = bus.m[WIDTH-1] ? -bus.m : bus.m;
  assign mag_n = bus.n[WIDTH-1] ? -bus.n : bus.n;
  assign z_nx  = sign_q ? -prod_nx : prod_nx;

  // Result sign is latched with the operands.
  always_ff @(posedge clk) begin
    if (rst)
      sign_q <= 1'b0;
    else if (state == IDLE && bus.start)
      sign_q <= bus.m[WIDTH-1] ^ bus.n[WIDTH-1];
  end
`else
  assign mag_m = bus.m;
  assign mag_n = bus.n;
  assign z_nx  = prod_nx;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nx;
  end

  // Next-state: start is only looked at in IDLE.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (bus.start) state_nx = RUN;
      RUN:  if (last)      state_nx = DONE;
      DONE:                state_nx = IDLE;
      default:             state_nx = IDLE;
    endcase
  end

  // Operand capture, iteration and result update.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q   <= '0;
      acc_q <= '0;
      q_q   <= '0;
      cnt_q <= '0;
      z_q   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            a_q   <= mag_m;
            q_q   <= mag_n;
            acc_q <= '0;
            cnt_q <= '0;
          end
        end
        RUN: begin
          {acc_q, q_q} <= prod_nx;
          cnt_q        <= cnt_q + CW'(1);
          if (last)
            z_q <= z_nx;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = (state == RUN);
  assign bus.done = (state == DONE);
  assign bus.z    = z_q;

endmodule
